// File: rtl/sklansky_sum_stage_if.sv
// Handshake and data bundle for the Sklansky sum stage: upstream PG input, downstream result.
// The ovf wire exists only when SUM_OVF_EN is defined.
interface sklansky_sum_stage_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   p_in;
    logic [WIDTH:0]   gi_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SUM_OVF_EN
    logic             ovf;
`endif

    // Upstream producer and downstream consumer together, as seen from outside the stage
    modport master (
        output in_valid,
        output p_in,
        output gi_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
`ifdef SUM_OVF_EN
        input  ovf,
`endif
        input  cout
    );

    // The stage itself
    modport slave (
        input  in_valid,
        input  p_in,
        input  gi_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
`ifdef SUM_OVF_EN
        output ovf,
`endif
        output cout
    );
endinterface

// File: rtl/sklansky_sum_stage.sv
// Final sum stage of a Sklansky prefix adder with a 2-entry (main + skid) output buffer.
// Optional signed-overflow output enabled by defining SUM_OVF_EN.
module sklansky_sum_stage #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sklansky_sum_stage_if.slave   bus
);

`ifdef SUM_OVF_EN
    localparam int ENTRY_W = WIDTH + 2;
`else
    localparam int ENTRY_W = WIDTH + 1;
`endif

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t               state_reg;
    logic                 in_ready_reg;
    logic                 out_valid_reg;
    logic [ENTRY_W-1:0]   main_reg;
    logic [ENTRY_W-1:0]   skid_reg;

    logic [WIDTH-1:0]     new_sum;
    logic [ENTRY_W-1:0]   new_entry;
    logic                 accept;
    logic                 drain;
    logic                 unused_p0;

    // Bit 0 of p_in is the carry-in slot; the carry itself arrives through gi_in[0]
    assign unused_p0 = bus.p_in[0];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sum
            assign new_sum[gi] = bus.p_in[gi+1] ^ bus.gi_in[gi];
        end
    endgenerate

`ifdef SUM_OVF_EN
    assign new_entry = {bus.gi_in[WIDTH] ^ bus.gi_in[WIDTH-1], bus.gi_in[WIDTH], new_sum};
`else
    assign new_entry = {bus.gi_in[WIDTH], new_sum};
`endif

    assign accept = bus.in_valid & in_ready_reg;
    assign drain  = out_valid_reg & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_EMPTY;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            main_reg      <= '0;
            skid_reg      <= '0;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        main_reg      <= new_entry;
                        state_reg     <= ST_ONE;
                        out_valid_reg <= 1'b1;
                    end else begin
                        out_valid_reg <= 1'b0;
                    end
                end
                ST_ONE: begin
                    case ({accept, drain})
                        2'b10: begin
                            skid_reg      <= new_entry;
                            state_reg     <= ST_FULL;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end
                        2'b01: begin
                            state_reg     <= ST_EMPTY;
                            in_ready_reg  <= 1'b1;
                            out_valid_reg <= 1'b0;
                        end
                        2'b11: begin
                            main_reg      <= new_entry;
                            in_ready_reg  <= 1'b1;
                            out_valid_reg <= 1'b1;
                        end
                        default: begin
                            in_ready_reg  <= 1'b1;
                            out_valid_reg <= 1'b1;
                        end
                    endcase
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can move the state
                    out_valid_reg <= 1'b1;
                    if (drain) begin
                        main_reg     <= skid_reg;
                        state_reg    <= ST_ONE;
                        in_ready_reg <= 1'b1;
                    end else begin
                        in_ready_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= ST_EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = main_reg[WIDTH-1:0];
    assign bus.cout      = main_reg[WIDTH];
`ifdef SUM_OVF_EN
    assign bus.ovf       = main_reg[WIDTH+1];
`endif

endmodule

// File: tb/tb_sklansky_sum_stage.sv
// Directed bench for sklansky_sum_stage: single ops, backpressure, streaming, reset mid-stream.
// Ovf checks are active when SUM_OVF_EN is defined.
module tb_sklansky_sum_stage;
    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sklansky_sum_stage_if #(.WIDTH(W)) bus ();

    sklansky_sum_stage #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference PG network: ripple carries, gi[k] = carry into bit k
    task automatic set_pg(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] c;
        c[0] = cin;
        for (int k = 0; k < W; k++)
            c[k+1] = (a[k] & b[k]) | ((a[k] ^ b[k]) & c[k]);
        bus.p_in  = {a ^ b, 1'b0};
        bus.gi_in = c;
    endtask

    task automatic exp_of(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] t;
        t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        s  = t[W-1:0];
        co = t[W];
        ov = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] s, input logic co, input logic ov);
        chk({tag, ".sum"}, 64'(bus.sum), 64'(s));
        chk({tag, ".cout"}, 64'(bus.cout), 64'(co));
`ifdef SUM_OVF_EN
        chk({tag, ".ovf"}, 64'(bus.ovf), 64'(ov));
`else
        if (ov === 1'bx) chk({tag, ".ovfx"}, 64'(ov), 64'd0);
`endif
    endtask

    // One op through an otherwise empty stage, called at a negedge
    task automatic single_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W-1:0] s;
        logic co, ov;
        exp_of(a, b, cin, s, co, ov);
        set_pg(a, b, cin);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        chk_out(tag, s, co, ov);
        $display("op %s: %h + %h + %0d -> sum=%h cout=%0d", tag, a, b, cin, bus.sum, bus.cout);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ea [3];
        logic [W-1:0] eb [3];
        logic [W-1:0] s;
        logic [W-1:0] hold_sum;
        logic co, ov;
        logic [W-1:0] a, b;
        logic cin;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.p_in  = '0;
        bus.gi_in = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.sum", 64'(bus.sum), 64'd0);
        chk("rst.cout", 64'(bus.cout), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rel.in_ready", 64'(bus.in_ready), 64'd1);
        chk("rel.out_valid", 64'(bus.out_valid), 64'd0);

        single_op("single", 16'h1234, 16'h0001, 1'b0);
        single_op("ripple", 16'hFFFF, 16'h0001, 1'b0);
        single_op("sovf", 16'h7FFF, 16'h0001, 1'b0);
        single_op("cin", 16'h00FF, 16'h0F00, 1'b1);

        // EMPTY: outputs must not move while nothing is accepted
        hold_sum = bus.sum;
        set_pg(16'hAAAA, 16'h1111, 1'b1);
        repeat (2) @(negedge clk);
        chk("empty.hold", 64'(bus.sum), 64'(hold_sum));

        // Backpressure: A and B accepted, C held until drain frees space
        ea[0] = 16'h0101; eb[0] = 16'h0202;
        ea[1] = 16'h8000; eb[1] = 16'h8000;
        ea[2] = 16'h1234; eb[2] = 16'h4321;
        bus.out_ready = 1'b0;
        set_pg(ea[0], eb[0], 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_of(ea[0], eb[0], 1'b0, s, co, ov);
        chk("bp.A.ready", 64'(bus.in_ready), 64'd1);
        chk_out("bp.A", s, co, ov);
        set_pg(ea[1], eb[1], 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("bp.full.ready", 64'(bus.in_ready), 64'd0);
        chk("bp.full.valid", 64'(bus.out_valid), 64'd1);
        chk_out("bp.A.stall1", s, co, ov);
        set_pg(ea[2], eb[2], 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("bp.C.blocked", 64'(bus.in_ready), 64'd0);
        chk_out("bp.A.stall2", s, co, ov);
        $display("bp: stalled on A sum=%h", bus.sum);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_of(ea[1], eb[1], 1'b0, s, co, ov);
        chk_out("bp.B", s, co, ov);
        chk("bp.B.ready", 64'(bus.in_ready), 64'd1);
        $display("bp: delivered B sum=%h", bus.sum);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        exp_of(ea[2], eb[2], 1'b0, s, co, ov);
        chk_out("bp.C", s, co, ov);
        chk("bp.C.valid", 64'(bus.out_valid), 64'd1);
        $display("bp: delivered C sum=%h", bus.sum);
        @(posedge clk);
        @(negedge clk);
        chk("bp.empty", 64'(bus.out_valid), 64'd0);

        // Streaming: one accept and one drain per cycle
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom_range(0, 1));
            set_pg(a, b, cin);
            chk("st.ready", 64'(bus.in_ready), 64'd1);
            @(posedge clk);
            @(negedge clk);
            exp_of(a, b, cin, s, co, ov);
            chk("st.valid", 64'(bus.out_valid), 64'd1);
            chk_out("st", s, co, ov);
            $display("stream %0d: %h + %h + %0d -> sum=%h cout=%0d", i, a, b, cin, bus.sum, bus.cout);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("st.empty", 64'(bus.out_valid), 64'd0);

        // Reset while FULL discards both entries at once
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        set_pg(16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_pg(16'h3333, 16'h4444, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("rm.full", 64'(bus.in_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rm.valid", 64'(bus.out_valid), 64'd0);
        chk("rm.ready", 64'(bus.in_ready), 64'd0);
        chk("rm.sum", 64'(bus.sum), 64'd0);
        set_pg(16'h5555, 16'h6666, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("rm.noacc", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rm.rel.ready", 64'(bus.in_ready), 64'd1);
        chk("rm.rel.valid", 64'(bus.out_valid), 64'd0);
        single_op("rm.first", 16'h0F0F, 16'h0101, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
